// File: rtl/ecg_pkg.sv
// Shared types and constants for the ADC-sample-to-UART path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ecg_pkg;

    // UART transmitter states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Default upper nibble of the first byte; lets the host find frame alignment.
    localparam logic [3:0] SYNC_NIBBLE_DEF = 4'hA;

    // Bytes per sample frame on the wire.
    localparam int FRAME_BYTES = 2;

    // Sample width delivered by the ADC core.
    localparam int SAMPLE_W = 12;

    // Byte sel=0 carries the sync nibble plus the sample MSBs, byte sel=1 the low byte.
    function automatic logic [7:0] frame_byte(input logic [3:0]          sync,
                                              input logic [SAMPLE_W-1:0] s,
                                              input logic                sel);
        return sel ? s[7:0] : {sync, s[11:8]};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO for ADC samples, depth 2**AW.
// Latency: write visible on rd_data the cycle after wr_en; rd_data valid in the same cycle as rd_en.
// Backpressure: writes on full are ignored unless a read happens in the same cycle.
module sample_fifo #(
    parameter int W  = 12,
    parameter int AW = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_wr;
    logic          do_rd;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign rd_data = mem_q[rd_ptr_q];
    assign do_rd   = rd_en & ~empty;
    // A read in the same cycle frees the slot, so a full FIFO still takes the write.
    assign do_wr   = wr_en & (~full | do_rd);

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally at AW bits; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/adc_sample_uart_tx.sv
// Captures each new 12-bit ADC sample on dv rising edge and sends it as a 2-byte 8N1 UART frame.
// Latency: push at edge N -> pop at N+1 -> tx start bit from edge N+2; 20 bit-times per sample.
// Backpressure: none upstream; samples arriving with the FIFO full are dropped and flagged in overflow.
module adc_sample_uart_tx
    import ecg_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         FIFO_AW      = 3,
    parameter logic [3:0] SYNC_NIBBLE  = SYNC_NIBBLE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] data,
    input  logic                dv,
    output logic                tx,
    output logic                busy,
    output logic                overflow
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_e         state_q, state_d;
    logic [CW-1:0]       baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shreg_q, shreg_d;
    logic [7:0]          lo_byte_q, lo_byte_d;
    logic                byte_sel_q, byte_sel_d;
    logic                tx_q, tx_d;
    logic                busy_q;
    logic                overflow_q;
    logic                dv_d_q;

    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [SAMPLE_W-1:0] fifo_rd_data;
    logic                baud_done;

    // One push per dv rising edge; a held level never pushes again.
    assign push      = dv & ~dv_d_q;
    assign baud_done = (baud_q == BAUD_LAST);

    sample_fifo #(
        .W  (SAMPLE_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Edge-detect history, sticky drop flag, and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_d_q     <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            dv_d_q <= dv;
            if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
            busy_q <= (state_q != ST_IDLE) | ~fifo_empty;
        end
    end

    // UART state, counters, shift register; tx is registered so reset forces idle-high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            lo_byte_q  <= '0;
            byte_sel_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            lo_byte_q  <= lo_byte_d;
            byte_sel_q <= byte_sel_d;
            tx_q       <= tx_d;
        end
    end

    // Next-state logic: each state lasts CLKS_PER_BIT cycles; byte1 follows byte0 with no idle gap.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + 1'b1;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        lo_byte_d  = lo_byte_q;
        byte_sel_d = byte_sel_q;
        tx_d       = 1'b1;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shreg_d    = frame_byte(SYNC_NIBBLE, fifo_rd_data, 1'b0);
                    lo_byte_d  = fifo_rd_data[7:0];
                    byte_sel_d = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d = shreg_q[0];
                if (baud_done) begin
                    baud_d  = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (baud_done) begin
                    baud_d = '0;
                    if (byte_sel_q != 1'(FRAME_BYTES - 1)) begin
                        byte_sel_d = 1'b1;
                        shreg_d    = lo_byte_q;
                        state_d    = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule
